// File: rtl/bot_regif_pkg.sv
// Register map and handshake state shared by the rojobot register interface.
package bot_regif_pkg;

    // Write offsets: shadow register loads
    localparam logic [3:0] OFS_LOCX    = 4'd0;
    localparam logic [3:0] OFS_LOCY    = 4'd1;
    localparam logic [3:0] OFS_SENSORS = 4'd2;
    localparam logic [3:0] OFS_BOTINFO = 4'd3;
    localparam logic [3:0] OFS_LMDIST  = 4'd4;
    localparam logic [3:0] OFS_RMDIST  = 4'd5;
    // Write offsets: control
    localparam logic [3:0] OFS_COMMIT  = 4'd8;
    localparam logic [3:0] OFS_CLR_OVR = 4'd9;

    // Read offsets
    localparam logic [3:0] OFS_MOTCTL  = 4'd0;
    localparam logic [3:0] OFS_CONFIG  = 4'd1;
    localparam logic [3:0] OFS_STATUS  = 4'd2;
    // Shadow readback sits three slots above the write offsets
    localparam logic [3:0] RD_LOCX     = 4'd3;
    localparam logic [3:0] RD_LOCY     = 4'd4;
    localparam logic [3:0] RD_SENSORS  = 4'd5;
    localparam logic [3:0] RD_BOTINFO  = 4'd6;
    localparam logic [3:0] RD_LMDIST   = 4'd7;
    localparam logic [3:0] RD_RMDIST   = 4'd8;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_t;

endpackage

// File: rtl/bot_regbank.sv
// One rojobot channel: shadow registers, committed system registers,
// update handshake FSM and sticky overrun flag.
module bot_regbank
    import bot_regif_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        ofs,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              upd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] locx,
    output logic [DATA_W-1:0] locy,
    output logic [DATA_W-1:0] sensors,
    output logic [DATA_W-1:0] botinfo,
    output logic [DATA_W-1:0] lmdist,
    output logic [DATA_W-1:0] rmdist,
    output logic              upd_sysregs,
    output logic              overrun
);

    logic [DATA_W-1:0] sh_locx, sh_locy, sh_sensors, sh_botinfo, sh_lmdist, sh_rmdist;
    hs_state_t state;

    logic commit, clr_ovr;
    assign commit  = wr_en && (ofs == OFS_COMMIT);
    assign clr_ovr = wr_en && (ofs == OFS_CLR_OVR);

    assign upd_sysregs = (state == HS_PENDING);

    // Shadow loads and commit copy into the system registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_locx    <= '0;
            sh_locy    <= '0;
            sh_sensors <= '0;
            sh_botinfo <= '0;
            sh_lmdist  <= '0;
            sh_rmdist  <= '0;
            locx       <= '0;
            locy       <= '0;
            sensors    <= '0;
            botinfo    <= '0;
            lmdist     <= '0;
            rmdist     <= '0;
        end else begin
            if (wr_en) begin
                case (ofs)
                    OFS_LOCX:    sh_locx    <= wr_data;
                    OFS_LOCY:    sh_locy    <= wr_data;
                    OFS_SENSORS: sh_sensors <= wr_data;
                    OFS_BOTINFO: sh_botinfo <= wr_data;
                    OFS_LMDIST:  sh_lmdist  <= wr_data;
                    OFS_RMDIST:  sh_rmdist  <= wr_data;
                    default: ;
                endcase
            end
            if (commit) begin
                locx    <= sh_locx;
                locy    <= sh_locy;
                sensors <= sh_sensors;
                botinfo <= sh_botinfo;
                lmdist  <= sh_lmdist;
                rmdist  <= sh_rmdist;
            end
        end
    end

    // Handshake FSM; a commit always wins over a same-cycle ack, and an
    // overrun set wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= HS_IDLE;
            overrun <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: begin
                    if (commit) state <= HS_PENDING;
                end
                HS_PENDING: begin
                    if (!commit && upd_ack) state <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
            if (commit && (state == HS_PENDING) && !upd_ack)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

    // Per-channel readback: status and shadow registers
    always_comb begin
        rd_data = '0;
        case (ofs)
            OFS_STATUS: rd_data[1:0] = {overrun, upd_sysregs};
            RD_LOCX:    rd_data = sh_locx;
            RD_LOCY:    rd_data = sh_locy;
            RD_SENSORS: rd_data = sh_sensors;
            RD_BOTINFO: rd_data = sh_botinfo;
            RD_LMDIST:  rd_data = sh_lmdist;
            RD_RMDIST:  rd_data = sh_rmdist;
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: rtl/bot_regif_n.sv
// Multi-bot PicoBlaze register interface: address decode, per-bot
// register banks and a registered read mux.
module bot_regif_n
    import bot_regif_pkg::*;
#(
    parameter int NUM_BOTS = 2,
    parameter int DATA_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [7:0]                   port_id,
    input  logic [DATA_W-1:0]            out_port,
    input  logic                         write_strobe,
    input  logic                         read_strobe,
    output logic [DATA_W-1:0]            in_port,
    input  logic [NUM_BOTS*DATA_W-1:0]   MotCtl_in,
    input  logic [NUM_BOTS*DATA_W-1:0]   Bot_Config_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   LocX_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   LocY_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   Sensors_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   BotInfo_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   LMDist_reg,
    output logic [NUM_BOTS*DATA_W-1:0]   RMDist_reg,
    output logic [NUM_BOTS-1:0]          upd_sysregs,
    input  logic [NUM_BOTS-1:0]          upd_ack,
    output logic [NUM_BOTS-1:0]          overrun
);

    // in_port refreshes every cycle, so the read qualifier carries no information here
    logic unused_rd_strobe;
    assign unused_rd_strobe = read_strobe;

    logic [2:0] bot_idx;
    logic [3:0] ofs;
    logic       addr_ok;

    assign bot_idx = port_id[6:4];
    assign ofs     = port_id[3:0];
    assign addr_ok = !port_id[7] && ({1'b0, bot_idx} < 4'(NUM_BOTS));

    logic [NUM_BOTS-1:0][DATA_W-1:0] bank_rd;
    logic [NUM_BOTS-1:0]             wr_en;

    for (genvar k = 0; k < NUM_BOTS; k++) begin : g_bot
        assign wr_en[k] = write_strobe && addr_ok && (bot_idx == 3'(k));

        bot_regbank #(.DATA_W(DATA_W)) u_bank (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr_en[k]),
            .ofs         (ofs),
            .wr_data     (out_port),
            .upd_ack     (upd_ack[k]),
            .rd_data     (bank_rd[k]),
            .locx        (LocX_reg[k*DATA_W +: DATA_W]),
            .locy        (LocY_reg[k*DATA_W +: DATA_W]),
            .sensors     (Sensors_reg[k*DATA_W +: DATA_W]),
            .botinfo     (BotInfo_reg[k*DATA_W +: DATA_W]),
            .lmdist      (LMDist_reg[k*DATA_W +: DATA_W]),
            .rmdist      (RMDist_reg[k*DATA_W +: DATA_W]),
            .upd_sysregs (upd_sysregs[k]),
            .overrun     (overrun[k])
        );
    end

    logic [DATA_W-1:0] rd_mux;

    // Select read data for the addressed bot; bad addresses read zero
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_BOTS; k++) begin
            if (addr_ok && (bot_idx == 3'(k))) begin
                case (ofs)
                    OFS_MOTCTL: rd_mux = MotCtl_in[k*DATA_W +: DATA_W];
                    OFS_CONFIG: rd_mux = Bot_Config_reg[k*DATA_W +: DATA_W];
                    default:    rd_mux = bank_rd[k];
                endcase
            end
        end
    end

    // Registered read data, one cycle behind port_id
    always_ff @(posedge clk) begin
        if (!reset) in_port <= '0;
        else        in_port <= rd_mux;
    end

endmodule

// File: tb/tb_bot_regif_n.sv
// Directed bench for bot_regif_n with an expectation queue drained by a monitor.
module tb_bot_regif_n;

    localparam int NB = 2;
    localparam int DW = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [7:0]         port_id;
    logic [DW-1:0]      out_port;
    logic               write_strobe;
    logic               read_strobe;
    logic [DW-1:0]      in_port;
    logic [NB*DW-1:0]   MotCtl_in;
    logic [NB*DW-1:0]   Bot_Config_reg;
    logic [NB*DW-1:0]   LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg;
    logic [NB-1:0]      upd_sysregs;
    logic [NB-1:0]      upd_ack;
    logic [NB-1:0]      overrun;

    bot_regif_n #(.NUM_BOTS(NB), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
        .MotCtl_in(MotCtl_in), .Bot_Config_reg(Bot_Config_reg),
        .LocX_reg(LocX_reg), .LocY_reg(LocY_reg), .Sensors_reg(Sensors_reg),
        .BotInfo_reg(BotInfo_reg), .LMDist_reg(LMDist_reg), .RMDist_reg(RMDist_reg),
        .upd_sysregs(upd_sysregs), .upd_ack(upd_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Signal codes for the scoreboard
    localparam int S_INPORT = 0, S_LOCX = 1, S_UPD = 2, S_OVR = 3, S_LOCY = 4, S_RMD = 5;

    int          q_due[$];
    int          q_sig[$];
    logic [63:0] q_val[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic string sig_name(int s);
        case (s)
            S_INPORT: return "in_port";
            S_LOCX:   return "LocX_reg";
            S_UPD:    return "upd_sysregs";
            S_OVR:    return "overrun";
            S_LOCY:   return "LocY_reg";
            default:  return "RMDist_reg";
        endcase
    endfunction

    function automatic logic [63:0] sig_val(int s);
        case (s)
            S_INPORT: return 64'(in_port);
            S_LOCX:   return 64'(LocX_reg);
            S_UPD:    return 64'(upd_sysregs);
            S_OVR:    return 64'(overrun);
            S_LOCY:   return 64'(LocY_reg);
            default:  return 64'(RMDist_reg);
        endcase
    endfunction

    // Expectation due after the next rising edge
    task automatic expect_nx(int s, logic [63:0] v);
        q_due.push_back(cyc + 1);
        q_sig.push_back(s);
        q_val.push_back(v);
    endtask

    // Monitor: registered outputs are stable at the falling edge
    always @(negedge clk) begin
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            automatic int          s = q_sig.pop_front();
            automatic logic [63:0] v = q_val.pop_front();
            automatic int          d = q_due.pop_front();
            automatic logic [63:0] a = sig_val(s);
            n_checks++;
            if (a === v) n_pass++;
            else $display("FAIL %s (due cyc %0d): got 0x%0h, expected 0x%0h", sig_name(s), d, a, v);
        end
    end

    // One strobed write cycle, optionally with an ack vector on the same edge
    task automatic wr(logic [7:0] p, logic [7:0] d, logic [NB-1:0] ack = '0);
        @(negedge clk);
        port_id = p; out_port = d; write_strobe = 1'b1; upd_ack = ack;
    endtask

    task automatic idle();
        @(negedge clk);
        write_strobe = 1'b0; read_strobe = 1'b0; upd_ack = '0;
    endtask

    task automatic rd(logic [7:0] p, logic [7:0] exp_v);
        @(negedge clk);
        port_id = p; write_strobe = 1'b0; read_strobe = 1'b1; upd_ack = '0;
        expect_nx(S_INPORT, 64'(exp_v));
    endtask

    initial begin
        reset = 1'b0; port_id = 8'h00; out_port = '0; write_strobe = 1'b0;
        read_strobe = 1'b0; upd_ack = '0;
        MotCtl_in = 16'hA55A; Bot_Config_reg = 16'h3CC3;

        // Reset state
        repeat (2) @(negedge clk);
        expect_nx(S_INPORT, 0); expect_nx(S_LOCX, 0);
        expect_nx(S_UPD, 0);    expect_nx(S_OVR, 0);
        @(negedge clk);
        reset = 1'b1;

        // Bot 1 shadow writes leave system registers untouched
        wr(8'h10, 8'h12);
        expect_nx(S_INPORT, 64'hA5);   // port 0x10 reads MotCtl bot 1
        expect_nx(S_LOCX, 0);
        wr(8'h11, 8'h34);
        wr(8'h15, 8'h56);
        wr(8'h18, 8'h00);
        expect_nx(S_LOCX, 64'h1200); expect_nx(S_LOCY, 64'h3400);
        expect_nx(S_RMD, 64'h5600);  expect_nx(S_UPD, 64'b10);
        idle();

        // Reads: status, shadow, config
        rd(8'h12, 8'h01);
        rd(8'h13, 8'h12);
        rd(8'h18, 8'h56);
        rd(8'h01, 8'hC3);
        idle();

        // Bot 0 double commit without ack -> overrun, second values win
        wr(8'h00, 8'h11);
        wr(8'h08, 8'h00);
        expect_nx(S_LOCX, 64'h1211); expect_nx(S_UPD, 64'b11); expect_nx(S_OVR, 0);
        wr(8'h00, 8'h22);
        wr(8'h08, 8'h00);
        expect_nx(S_LOCX, 64'h1222); expect_nx(S_OVR, 64'b01); expect_nx(S_UPD, 64'b11);
        idle();
        rd(8'h02, 8'h03);
        wr(8'h09, 8'h00);
        expect_nx(S_OVR, 0);
        idle();

        // Commit with same-cycle ack while pending: stay pending, no overrun
        wr(8'h08, 8'h00, 2'b01);
        expect_nx(S_UPD, 64'b11); expect_nx(S_OVR, 0);
        idle();
        // Ack alone releases bot 0; bot 1 untouched
        @(negedge clk); upd_ack = 2'b01;
        expect_nx(S_UPD, 64'b10);
        idle();
        // Ack in IDLE has no effect
        @(negedge clk); upd_ack = 2'b01;
        expect_nx(S_UPD, 64'b10); expect_nx(S_OVR, 0);
        idle();

        // Out-of-range bot, unlisted offset, bit 7 set
        wr(8'h70, 8'hFF);
        wr(8'h78, 8'h00);
        expect_nx(S_LOCX, 64'h1222); expect_nx(S_UPD, 64'b10); expect_nx(S_OVR, 0);
        wr(8'h88, 8'h00);
        expect_nx(S_UPD, 64'b10);
        idle();
        rd(8'h70, 8'h00);
        rd(8'h0A, 8'h00);
        rd(8'h90, 8'h00);
        rd(8'h10, 8'hA5);
        idle();

        // Reset while bot 1 pending clears everything
        @(negedge clk); reset = 1'b0; port_id = 8'h13;
        expect_nx(S_LOCX, 0); expect_nx(S_UPD, 0); expect_nx(S_OVR, 0);
        expect_nx(S_INPORT, 0); expect_nx(S_RMD, 0);
        // Strobes during reset ignored
        wr(8'h18, 8'h00);
        expect_nx(S_UPD, 0); expect_nx(S_LOCX, 0);
        idle();
        @(negedge clk); reset = 1'b1; upd_ack = 2'b11;
        expect_nx(S_UPD, 0); expect_nx(S_OVR, 0);
        idle();
        rd(8'h13, 8'h00);
        idle();

        // Drain the scoreboard with a bound
        for (int i = 0; i < 20 && q_due.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q_due.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q_due.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bot_regif_n.md
BOT_REGIF_N -- requirements
Module: bot_regif_n

Interface
REQ-001 The block SHALL have parameter NUM_BOTS, default 2, number of rojobot register channels (legal 1..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, width of every register and I/O data path.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, single system clock, all logic on rising edge.
- reset, input, 1, synchronous active-low reset.
- port_id, input, 8, PicoBlaze I/O address: [6:4] bot index, [3:0] register offset.
- out_port, input, DATA_W, PicoBlaze write data.
- write_strobe, input, 1, one-cycle write qualifier.
- read_strobe, input, 1, one-cycle read qualifier.
- in_port, output, DATA_W, registered PicoBlaze read data.
- MotCtl_in, input, NUM_BOTS*DATA_W, per-bot motor control, bot k at slice k.
- Bot_Config_reg, input, NUM_BOTS*DATA_W, per-bot configuration.
- LocX_reg, LocY_reg, Sensors_reg, BotInfo_reg, LMDist_reg, RMDist_reg, outputs, NUM_BOTS*DATA_W each, committed system registers.
- upd_sysregs, output, NUM_BOTS, per-bot update-pending flag.
- upd_ack, input, NUM_BOTS, per-bot acknowledge from the application CPU.
- overrun, output, NUM_BOTS, per-bot sticky overrun flag.

Function
REQ-004 Write offsets 0..5 SHALL load bot-k shadow registers LocX, LocY, Sensors, BotInfo, LMDist, RMDist on the clock edge where write_strobe=1; system outputs SHALL NOT change.
REQ-005 A write to offset 8 (COMMIT) SHALL copy all six shadow registers of bot k to its system outputs on the same edge, with the copies visible the next cycle.
REQ-006 A write to offset 9 (CLR_OVR) SHALL clear overrun[k].
REQ-007 Read offsets SHALL return: 0 MotCtl_in slice k; 1 Bot_Config_reg slice k; 2 status {overrun[k], upd_sysregs[k]} in bits [1:0], upper bits zero; 3..8 shadow LocX..RMDist.
REQ-008 in_port SHALL be registered: data for the port_id present on cycle n SHALL appear on cycle n+1, and in_port SHALL update every cycle regardless of read_strobe.
REQ-009 A bot index >= NUM_BOTS, an unlisted offset, or port_id[7]=1 SHALL read 0 and SHALL ignore writes.
REQ-010 Each bot SHALL have a two-state handshake FSM with states IDLE and PENDING; upd_sysregs[k]=1 in PENDING.
REQ-011 The FSM SHALL go IDLE->PENDING on COMMIT and PENDING->IDLE on upd_ack[k]=1 with no COMMIT.
REQ-012 COMMIT while PENDING with upd_ack[k]=0 SHALL set overrun[k], update the outputs, and stay in PENDING.
REQ-013 COMMIT and upd_ack[k] on the same cycle SHALL leave the FSM in PENDING and SHALL NOT set overrun.
REQ-014 upd_ack[k] in IDLE SHALL have no effect.
REQ-015 CLR_OVR and an overrun-setting COMMIT on the same cycle SHALL leave overrun[k]=1 (set wins).
REQ-016 Channels SHALL be fully independent; traffic on bot j SHALL NOT alter any state of bot k.

Reset
REQ-017 When reset=0 at a clock edge, all shadow and system registers, in_port, upd_sysregs and overrun SHALL become 0 and every FSM SHALL enter IDLE.
REQ-018 A reset asserted mid-handshake SHALL discard the pending update and SHALL NOT require an ack.
REQ-019 Strobes sampled while reset=0 SHALL be ignored.

Structure
REQ-020 Package bot_regif_pkg SHALL hold the register offset constants (OFS_LOCX..OFS_RMDIST, OFS_COMMIT=8, OFS_CLR_OVR=9, OFS_MOTCTL=0, OFS_CONFIG=1, OFS_STATUS=2) and the handshake state typedef.
REQ-021 Per-bot logic (shadow registers, system registers, FSM, overrun) SHALL be sub-module bot_regbank, instantiated NUM_BOTS times by generate.
REQ-022 The top level SHALL contain only address decode and the registered read mux.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write 0x12 to port 0x10, then COMMIT on port 0x18: LocX_reg[15:8]=0x12 on the next cycle, upd_sysregs=2'b10.
- Read port 0x12 while bot 1 is pending: in_port=0x01 one cycle later.
- Two COMMITs to bot 0 with no ack: overrun[0]=1, outputs hold the second values, then a write to 0x09 clears overrun.
- COMMIT and upd_ack[0] on the same cycle while pending: upd_sysregs[0]=1 and overrun[0]=0.
- Write to port 0x70 with NUM_BOTS=2: no output changes, and a read of 0x70 returns 0x00.
- reset=0 during PENDING: all outputs 0 on the next cycle, and a later upd_ack has no effect.
